// File: rtl/hazard_scoreboard_if.sv
// Decode-stage tags and hazard/forwarding controls between the Y86-64 datapath and its scoreboard.
// The datapath side drives the D-stage tags and condition/exception flags and receives the controls.
interface hazard_scoreboard_if #(
    parameter int CNT_W = 32
);
    logic [3:0]       d_icode;
    logic [3:0]       d_srcA;
    logic [3:0]       d_srcB;
    logic [3:0]       d_dstE;
    logic [3:0]       d_dstM;
    logic             e_Cnd;
    logic             m_exc;
    logic             w_exc;
    logic             f_stall;
    logic             d_stall;
    logic             d_bubble;
    logic             e_bubble;
    logic             m_bubble;
    logic             w_stall;
    logic [2:0]       fwdA_sel;
    logic [2:0]       fwdB_sel;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output d_icode, d_srcA, d_srcB, d_dstE, d_dstM, e_Cnd, m_exc, w_exc,
        input  f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall,
        input  fwdA_sel, fwdB_sel, stall_cnt
    );

    modport slave (
        input  d_icode, d_srcA, d_srcB, d_dstE, d_dstM, e_Cnd, m_exc, w_exc,
        output f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall,
        output fwdA_sel, fwdB_sel, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Y86-64 pipeline control: shadows the E/M/W register tags, derives stall/bubble controls,
// selects decode operand forwarding sources and counts fetch-stall cycles.
module hazard_scoreboard #(
    parameter int CNT_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    hazard_scoreboard_if.slave  hz
);
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] ICMOVXX = 4'h2;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPOPQ   = 4'hB;
    localparam logic [3:0] RNONE   = 4'hF;

    logic [3:0] ex_icode_reg, ex_dste_reg, ex_dstm_reg;
    logic [3:0] mem_icode_reg, mem_dste_reg, mem_dstm_reg;
    logic [3:0] wb_icode_reg, wb_dste_reg, wb_dstm_reg;
    logic [CNT_W-1:0] stall_cnt_reg;

    logic [3:0] ex_dste_eff;
    logic       load_use, ret_pend, mispred, exc;
    logic       f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall;

    // A not-taken conditional move writes nothing, so its destination must not forward
    assign ex_dste_eff = (ex_icode_reg == ICMOVXX && !hz.e_Cnd) ? RNONE : ex_dste_reg;

    assign load_use = (ex_icode_reg == IMRMOVQ || ex_icode_reg == IPOPQ) &&
                      (ex_dstm_reg != RNONE) &&
                      (ex_dstm_reg == hz.d_srcA || ex_dstm_reg == hz.d_srcB);
    assign ret_pend = (hz.d_icode == IRET) || (ex_icode_reg == IRET) || (mem_icode_reg == IRET);
    assign mispred  = (ex_icode_reg == IJXX) && !hz.e_Cnd;
    assign exc      = hz.m_exc || hz.w_exc;

    // With load-use and ret together, holding D takes precedence over bubbling it
    assign f_stall  = load_use || ret_pend;
    assign d_stall  = load_use;
    assign d_bubble = mispred || (ret_pend && !load_use);
    assign e_bubble = mispred || load_use;
    assign m_bubble = exc;
    assign w_stall  = hz.w_exc;

    assign hz.f_stall   = f_stall;
    assign hz.d_stall   = d_stall;
    assign hz.d_bubble  = d_bubble;
    assign hz.e_bubble  = e_bubble;
    assign hz.m_bubble  = m_bubble;
    assign hz.w_stall   = w_stall;
    assign hz.stall_cnt = stall_cnt_reg;

    // Forwarding candidates, index order is priority order (youngest first)
    logic [3:0] fwd_tag [5];
    logic [4:0] hit_a, hit_b;

    assign fwd_tag[0] = ex_dste_eff;
    assign fwd_tag[1] = mem_dstm_reg;
    assign fwd_tag[2] = mem_dste_reg;
    assign fwd_tag[3] = wb_dstm_reg;
    assign fwd_tag[4] = wb_dste_reg;

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_hit
            assign hit_a[gi] = (hz.d_srcA != RNONE) && (fwd_tag[gi] == hz.d_srcA);
            assign hit_b[gi] = (hz.d_srcB != RNONE) && (fwd_tag[gi] == hz.d_srcB);
        end
    endgenerate

    logic [2:0] sel_a, sel_b;

    always_comb begin
        sel_a = 3'd0;
        sel_b = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (hit_a[i]) sel_a = 3'(i + 2);
            if (hit_b[i]) sel_b = 3'(i + 2);
        end
        if (hz.d_icode == ICALL || hz.d_icode == IJXX) sel_a = 3'd1;
    end

    assign hz.fwdA_sel = sel_a;
    assign hz.fwdB_sel = sel_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_icode_reg  <= INOP;
            ex_dste_reg   <= RNONE;
            ex_dstm_reg   <= RNONE;
            mem_icode_reg <= INOP;
            mem_dste_reg  <= RNONE;
            mem_dstm_reg  <= RNONE;
            wb_icode_reg  <= INOP;
            wb_dste_reg   <= RNONE;
            wb_dstm_reg   <= RNONE;
            stall_cnt_reg <= '0;
        end else begin
            if (e_bubble) begin
                ex_icode_reg <= INOP;
                ex_dste_reg  <= RNONE;
                ex_dstm_reg  <= RNONE;
            end else begin
                ex_icode_reg <= hz.d_icode;
                ex_dste_reg  <= hz.d_dstE;
                ex_dstm_reg  <= hz.d_dstM;
            end

            if (m_bubble) begin
                mem_icode_reg <= INOP;
                mem_dste_reg  <= RNONE;
                mem_dstm_reg  <= RNONE;
            end else begin
                mem_icode_reg <= ex_icode_reg;
                mem_dste_reg  <= ex_dste_eff;
                mem_dstm_reg  <= ex_dstm_reg;
            end

            if (!w_stall) begin
                wb_icode_reg <= mem_icode_reg;
                wb_dste_reg  <= mem_dste_reg;
                wb_dstm_reg  <= mem_dstm_reg;
            end

            if (f_stall && stall_cnt_reg != {CNT_W{1'b1}})
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed checks of hazard_scoreboard: load-use, mispredict, ret, cmov/priority forwarding,
// exceptions, W hold and asynchronous reset during a stall.
module tb_hazard_scoreboard;
    localparam logic [3:0] INOP = 4'h1, ICMOVXX = 4'h2, IIRMOVQ = 4'h3, IMRMOVQ = 4'h5,
                           IOPQ = 4'h6, IJXX = 4'h7, ICALL = 4'h8, IRET = 4'h9, RN = 4'hF;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    hazard_scoreboard_if #(.CNT_W(32)) hz ();

    hazard_scoreboard #(.CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall}
    logic [5:0] ctl;
    assign ctl = {hz.f_stall, hz.d_stall, hz.d_bubble, hz.e_bubble, hz.m_bubble, hz.w_stall};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-12s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic drv(input logic [3:0] ic, input logic [3:0] sa, input logic [3:0] sb,
                       input logic [3:0] de, input logic [3:0] dm);
        hz.d_icode = ic;
        hz.d_srcA  = sa;
        hz.d_srcB  = sb;
        hz.d_dstE  = de;
        hz.d_dstM  = dm;
    endtask

    task automatic flush();
        repeat (3) begin
            @(negedge clk);
            drv(INOP, RN, RN, RN, RN);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        hz.e_Cnd = 1'b0;
        hz.m_exc = 1'b0;
        hz.w_exc = 1'b0;
        drv(INOP, RN, RN, RN, RN);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ctl", 32'(ctl), 32'h0);
        chk("rst_fwdA", 32'(hz.fwdA_sel), 32'd0);
        chk("rst_fwdB", 32'(hz.fwdB_sel), 32'd0);
        chk("rst_cnt", hz.stall_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Load-use: mrmovq into r3 followed by a consumer of r3
        drv(IMRMOVQ, RN, RN, RN, 4'h3);
        #1 chk("lu_pre", 32'(ctl), 32'h0);
        @(negedge clk);
        drv(IOPQ, 4'h3, 4'h4, 4'h4, RN);
        #1 chk("lu_ctl", 32'(ctl), 32'b110100);
        chk("lu_fwdA0", 32'(hz.fwdA_sel), 32'd0);
        @(negedge clk);
        #1 chk("lu_after", 32'(ctl), 32'h0);
        chk("lu_fwdA", 32'(hz.fwdA_sel), 32'd3);
        chk("lu_cnt", hz.stall_cnt, 32'd1);
        flush();

        // Mispredicted jump
        @(negedge clk);
        drv(IJXX, RN, RN, RN, RN);
        @(negedge clk);
        drv(IOPQ, RN, RN, RN, RN);
        hz.e_Cnd = 1'b0;
        #1 chk("jxx_ctl", 32'(ctl), 32'b001100);
        @(negedge clk);
        drv(INOP, RN, RN, RN, RN);
        #1 chk("jxx_after", 32'(ctl), 32'h0);

        // ret travelling through D, E, M
        @(negedge clk);
        drv(IRET, RN, RN, RN, RN);
        #1 chk("ret_d", 32'(ctl), 32'b101000);
        @(negedge clk);
        drv(INOP, RN, RN, RN, RN);
        #1 chk("ret_e", 32'(ctl), 32'b101000);
        @(negedge clk);
        #1 chk("ret_m", 32'(ctl), 32'b101000);
        @(negedge clk);
        #1 chk("ret_done", 32'(ctl), 32'h0);
        chk("ret_cnt", hz.stall_cnt, 32'd4);
        flush();

        // Conditional move forwarding: irmovq r2 in W, cmovxx r2 in E
        hz.e_Cnd = 1'b1;
        @(negedge clk);
        drv(IIRMOVQ, RN, RN, 4'h2, RN);
        @(negedge clk);
        drv(INOP, RN, RN, RN, RN);
        @(negedge clk);
        drv(ICMOVXX, 4'h1, RN, 4'h2, RN);
        @(negedge clk);
        drv(IOPQ, 4'h2, RN, 4'h2, RN);
        #1 chk("cmov_t", 32'(hz.fwdA_sel), 32'd2);
        hz.e_Cnd = 1'b0;
        #1 chk("cmov_f", 32'(hz.fwdA_sel), 32'd6);
        chk("cmov_ctl", 32'(ctl), 32'h0);
        hz.e_Cnd = 1'b1;
        flush();

        // Priority: M_dstM = M_dstE = W_dstE = r5
        @(negedge clk);
        drv(IOPQ, RN, RN, 4'h5, RN);
        @(negedge clk);
        drv(IOPQ, RN, RN, 4'h5, 4'h5);
        @(negedge clk);
        drv(INOP, RN, RN, RN, RN);
        @(negedge clk);
        drv(ICALL, RN, 4'h5, 4'h4, RN);
        #1 chk("call_fwdA", 32'(hz.fwdA_sel), 32'd1);
        chk("prio_fwdB", 32'(hz.fwdB_sel), 32'd3);
        drv(IOPQ, RN, 4'h5, RN, RN);
        #1 chk("rnone_fwdA", 32'(hz.fwdA_sel), 32'd0);
        chk("prio_fwdB2", 32'(hz.fwdB_sel), 32'd3);
        flush();

        // Exceptions and W hold
        @(negedge clk);
        hz.m_exc = 1'b1;
        drv(INOP, RN, RN, RN, RN);
        #1 chk("mexc_ctl", 32'(ctl), 32'b000010);
        @(negedge clk);
        hz.m_exc = 1'b0;
        drv(IOPQ, RN, RN, 4'h7, RN);
        @(negedge clk);
        drv(INOP, RN, RN, RN, RN);
        @(negedge clk);
        @(negedge clk);
        hz.w_exc = 1'b1;
        #1 chk("wexc_ctl", 32'(ctl), 32'b000011);
        @(negedge clk);
        @(negedge clk);
        #1 chk("whold_mid", 32'(ctl), 32'b000011);
        @(negedge clk);
        hz.w_exc = 1'b0;
        drv(IOPQ, 4'h7, RN, RN, RN);
        #1 chk("whold_fwdA", 32'(hz.fwdA_sel), 32'd6);
        flush();

        // Load-use together with ret, then reset in the middle of the ret stall
        @(negedge clk);
        drv(IMRMOVQ, RN, RN, RN, 4'h4);
        @(negedge clk);
        drv(IRET, 4'h4, 4'h4, RN, RN);
        #1 chk("luret_ctl", 32'(ctl), 32'b110100);
        chk("luret_cnt", hz.stall_cnt, 32'd4);
        @(negedge clk);
        #1 chk("luret2_ctl", 32'(ctl), 32'b101000);
        chk("luret2_cnt", hz.stall_cnt, 32'd5);
        @(negedge clk);
        drv(INOP, RN, RN, RN, RN);
        #1 chk("rete_ctl", 32'(ctl), 32'b101000);
        chk("rete_cnt", hz.stall_cnt, 32'd6);
        #1 rst_n = 1'b0;
        #1 chk("arst_ctl", 32'(ctl), 32'h0);
        chk("arst_cnt", hz.stall_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("post_ctl", 32'(ctl), 32'h0);
        chk("post_cnt", hz.stall_cnt, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
